da_pulse_sequencer: RTL and testbench

//   Upstream driver of the D/A converter stage: accepts single-cycle +/- count

---
 rtl/da_pulse_if.sv | 27 ++
 rtl/da_pulse_sequencer.sv | 149 ++++++++++++++
 tb/tb_da_pulse_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/da_pulse_if.sv
// Bundle of the sequencer's control inputs and D/A-side outputs.
//   master: the command source (drives enable/zero/cmd_p/cmd_m, observes status)
//   slave : the sequencer (drives ApPGH/AmPGH/err_count/pending/busy/sat)
interface da_pulse_if #(
    parameter int WIDTH = 10
);
    logic                    enable;
    logic                    zero;
    logic                    cmd_p;
    logic                    cmd_m;
    logic                    ApPGH;
    logic                    AmPGH;
    logic signed [WIDTH-1:0] err_count;
    logic signed [WIDTH-1:0] pending;
    logic                    busy;
    logic                    sat;

    modport master (
        output enable, zero, cmd_p, cmd_m,
        input  ApPGH, AmPGH, err_count, pending, busy, sat
    );

    modport slave (
        input  enable, zero, cmd_p, cmd_m,
        output ApPGH, AmPGH, err_count, pending, busy, sat
    );
endinterface

// File: rtl/da_pulse_sequencer.sv
// Upstream driver of the D/A converter stage. Accumulates single-cycle +/- count
// commands and replays them as paced, fixed-width ApPGH / AmPGH pulses, one per
// pacing tick, while tracking the signed error count the D/A output represents.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : da_pulse_if.slave (enable, zero, cmd_p, cmd_m in;
//          ApPGH, AmPGH, err_count, pending, busy, sat out)
//
// state | meaning
// IDLE  | no pulse active; a tick may launch one if enable and pending != 0
// PLUS  | ApPGH held high for PULSE_LEN cycles
// MINUS | AmPGH held high for PULSE_LEN cycles
module da_pulse_sequencer #(
    parameter int WIDTH     = 10,
    parameter int LIMIT     = 384,
    parameter int DIVIDER   = 16,
    parameter int PULSE_LEN = 4
) (
    input logic        clk,
    input logic        rst,
    da_pulse_if.slave  bus
);
    localparam int TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int SW = WIDTH + 2;

    localparam logic [TW-1:0]         TICK_LAST = TW'(DIVIDER - 1);
    localparam logic [PW-1:0]         PULSE_RELOAD = PW'(PULSE_LEN - 1);
    localparam logic signed [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic signed [WIDTH-1:0] E_MAX = WIDTH'(LIMIT);
    localparam logic signed [WIDTH-1:0] E_MIN = WIDTH'(-LIMIT);
    localparam logic signed [SW-1:0]  SUM_MAX = SW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0]  SUM_MIN = SW'(-((2 ** (WIDTH - 1)) - 1));
    localparam logic signed [SW-1:0]  S_ONE   = SW'(1);
    localparam logic signed [SW-1:0]  S_MONE  = SW'(-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLUS  = 2'd1,
        MINUS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tick_q;
    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic signed [WIDTH-1:0] err_q, err_d;
    logic signed [WIDTH-1:0] pend_q, pend_d;
    logic                    sat_q, sat_d;
    logic                    tick;
    logic                    pend_pos, pend_neg;
    logic signed [SW-1:0]    cmd_delta, issue_delta, pend_sum;

    assign tick     = (tick_q == TICK_LAST);
    assign pend_pos = ~pend_q[WIDTH-1] & (pend_q != '0);
    assign pend_neg = pend_q[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        err_d       = err_q;
        sat_d       = sat_q;
        cmd_delta   = '0;
        issue_delta = '0;
        pend_d      = pend_q;

        if (bus.cmd_p && !bus.cmd_m) begin
            cmd_delta = S_ONE;
        end else if (bus.cmd_m && !bus.cmd_p) begin
            cmd_delta = S_MONE;
        end

        case (state_q)
            IDLE: begin
                if (tick && bus.enable) begin
                    // A count at the limit is still consumed from pending, just not issued.
                    if (pend_pos) begin
                        issue_delta = S_MONE;
                        if (err_q == E_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            state_d = PLUS;
                            pcnt_d  = PULSE_RELOAD;
                            err_d   = err_q + ONE;
                        end
                    end else if (pend_neg) begin
                        issue_delta = S_ONE;
                        if (err_q == E_MIN) begin
                            sat_d = 1'b1;
                        end else begin
                            state_d = MINUS;
                            pcnt_d  = PULSE_RELOAD;
                            err_d   = err_q - ONE;
                        end
                    end
                end
            end
            PLUS, MINUS: begin
                if (pcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q - PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        pend_sum = {{2{pend_q[WIDTH-1]}}, pend_q} + cmd_delta + issue_delta;
        if (pend_sum > SUM_MAX) begin
            pend_d = SUM_MAX[WIDTH-1:0];
        end else if (pend_sum < SUM_MIN) begin
            pend_d = SUM_MIN[WIDTH-1:0];
        end else begin
            pend_d = pend_sum[WIDTH-1:0];
        end

        if (bus.zero) begin
            state_d = IDLE;
            pcnt_d  = '0;
            err_d   = '0;
            pend_d  = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            pend_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick ? '0 : tick_q + TW'(1);
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.ApPGH     = (state_q == PLUS);
    assign bus.AmPGH     = (state_q == MINUS);
    assign bus.err_count = err_q;
    assign bus.pending   = pend_q;
    assign bus.busy      = (state_q != IDLE) || (pend_q != '0);
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_da_pulse_sequencer.sv
module tb_da_pulse_sequencer;
    localparam int WIDTH     = 10;
    localparam int LIMIT     = 384;
    localparam int DIVIDER   = 16;
    localparam int PULSE_LEN = 4;
    localparam int PMAX      = 2 ** (WIDTH - 1) - 1;

    logic clk = 1'b0;
    logic rst;

    da_pulse_if #(.WIDTH(WIDTH)) bus ();

    da_pulse_sequencer #(
        .WIDTH(WIDTH), .LIMIT(LIMIT), .DIVIDER(DIVIDER), .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: counts, not states
    int m_pend  = 0;
    int m_err   = 0;
    int m_sat   = 0;
    int m_phase = 0;
    int m_left  = 0;
    int m_dir   = 0;

    int cyc = 0;
    int p_rise[$];
    int m_rise[$];
    logic prev_ap = 1'b0;
    logic prev_am = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > PMAX) return PMAX;
        if (v < -PMAX) return -PMAX;
        return v;
    endfunction

    task automatic model_step();
        int tick_now;
        int s;
        int adj;
        int cmd;
        if (rst) begin
            m_pend = 0; m_err = 0; m_sat = 0; m_phase = 0; m_left = 0; m_dir = 0;
            return;
        end
        tick_now = (m_phase == DIVIDER - 1);
        m_phase  = (m_phase + 1) % DIVIDER;
        if (bus.zero) begin
            m_pend = 0; m_err = 0; m_sat = 0; m_left = 0;
            return;
        end
        cmd = int'(bus.cmd_p) - int'(bus.cmd_m);
        adj = 0;
        if (m_left > 0) begin
            m_left--;
        end else if (tick_now != 0 && bus.enable && m_pend != 0) begin
            s   = (m_pend > 0) ? 1 : -1;
            adj = -s;
            if (m_err * s == LIMIT) begin
                m_sat = 1;
            end else begin
                m_err  += s;
                m_left = PULSE_LEN;
                m_dir  = s;
            end
        end
        m_pend = clamp(m_pend + cmd + adj);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("ApPGH",     int'(bus.ApPGH),     (m_left > 0 && m_dir > 0) ? 1 : 0);
        chk("AmPGH",     int'(bus.AmPGH),     (m_left > 0 && m_dir < 0) ? 1 : 0);
        chk("err_count", int'(bus.err_count), m_err);
        chk("pending",   int'(bus.pending),   m_pend);
        chk("busy",      int'(bus.busy),      (m_left > 0 || m_pend != 0) ? 1 : 0);
        chk("sat",       int'(bus.sat),       m_sat);
        if (bus.ApPGH && bus.AmPGH) chk("both_pulses", 1, 0);
        if (bus.ApPGH && !prev_ap) p_rise.push_back(cyc);
        if (bus.AmPGH && !prev_am) m_rise.push_back(cyc);
        prev_ap = bus.ApPGH;
        prev_am = bus.AmPGH;
    endtask

    task automatic strobe(input logic p, input logic m);
        bus.cmd_p = p;
        bus.cmd_m = m;
        cycle();
        bus.cmd_p = 1'b0;
        bus.cmd_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        p_rise.delete();
        m_rise.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            cycle();
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_pulse(input int budget);
        int n = 0;
        while (!(bus.ApPGH || bus.AmPGH) && n < budget) begin
            cycle();
            n++;
        end
        if (!(bus.ApPGH || bus.AmPGH)) chk("pulse_timeout", 0, 1);
    endtask

    task automatic check_gaps(input string tag, input int q[$]);
        for (int i = 1; i < q.size(); i++) chk(tag, q[i] - q[i-1], DIVIDER);
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.zero   = 1'b0;
        bus.cmd_p  = 1'b0;
        bus.cmd_m  = 1'b0;

        // reset state
        do_reset();
        chk("rst_err",  int'(bus.err_count), 0);
        chk("rst_pend", int'(bus.pending), 0);
        chk("rst_ap",   int'(bus.ApPGH), 0);

        // three + counts paced one per tick
        bus.enable = 1'b1;
        repeat (3) strobe(1'b1, 1'b0);
        wait_idle(200);
        chk("t1_pulses", p_rise.size(), 3);
        check_gaps("t1_gap", p_rise);
        chk("t1_err",  int'(bus.err_count), 3);
        chk("t1_pend", int'(bus.pending), 0);

        // simultaneous strobes cancel; then two - counts
        do_reset();
        bus.enable = 1'b1;
        strobe(1'b1, 1'b1);
        chk("t2_cancel", int'(bus.pending), 0);
        repeat (40) cycle();
        chk("t2_none", p_rise.size() + m_rise.size(), 0);
        repeat (2) strobe(1'b0, 1'b1);
        wait_idle(200);
        chk("t2_mpulses", m_rise.size(), 2);
        chk("t2_ppulses", p_rise.size(), 0);
        chk("t2_err", int'(bus.err_count), -2);

        // saturation at +LIMIT: three counts beyond LIMIT-1
        do_reset();
        bus.enable = 1'b1;
        repeat (LIMIT + 2) strobe(1'b1, 1'b0);
        wait_idle((LIMIT + 4) * DIVIDER);
        chk("t3_err",     int'(bus.err_count), LIMIT);
        chk("t3_sat",     int'(bus.sat), 1);
        chk("t3_pend",    int'(bus.pending), 0);
        chk("t3_pulses",  p_rise.size(), LIMIT);

        // pending saturates at the top of its range
        bus.enable = 1'b0;
        repeat (PMAX + 8) strobe(1'b1, 1'b0);
        chk("pend_sat", int'(bus.pending), PMAX);
        bus.zero = 1'b1;
        cycle();
        bus.zero = 1'b0;
        chk("zero_sat", int'(bus.sat), 0);

        // enable low holds pulses back
        do_reset();
        repeat (5) strobe(1'b0, 1'b1);
        repeat (40) cycle();
        chk("t4_pend", int'(bus.pending), -5);
        chk("t4_none", m_rise.size(), 0);
        bus.enable = 1'b1;
        wait_idle(200);
        chk("t4_pulses", m_rise.size(), 5);
        check_gaps("t4_gap", m_rise);

        // zero during the second cycle of a + pulse
        do_reset();
        repeat (8) strobe(1'b1, 1'b0);
        bus.enable = 1'b1;
        wait_pulse(40);
        cycle();
        chk("t5_ap_before",  int'(bus.ApPGH), 1);
        chk("t5_pend_before", int'(bus.pending), 7);
        bus.zero  = 1'b1;
        bus.cmd_p = 1'b1;
        cycle();
        bus.zero  = 1'b0;
        bus.cmd_p = 1'b0;
        chk("t5_ap",   int'(bus.ApPGH), 0);
        chk("t5_err",  int'(bus.err_count), 0);
        chk("t5_pend", int'(bus.pending), 0);

        // reset mid - pulse
        do_reset();
        bus.enable = 1'b0;
        repeat (5) strobe(1'b0, 1'b1);
        bus.enable = 1'b1;
        wait_pulse(40);
        chk("t6_pend_before", int'(bus.pending), -4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_am",   int'(bus.AmPGH), 0);
        chk("t6_pend", int'(bus.pending), 0);
        chk("t6_busy", int'(bus.busy), 0);

        // randomized traffic against the model
        bus.enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bus.cmd_p = ($urandom_range(0, 3) == 0);
            bus.cmd_m = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
            bus.zero = ($urandom_range(0, 299) == 0);
            rst      = ($urandom_range(0, 799) == 0);
            cycle();
        end
        bus.cmd_p = 1'b0;
        bus.cmd_m = 1'b0;
        bus.zero  = 1'b0;
        rst       = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
